// File: rtl/mod_74x163_if.sv
// Pin bundle of one 74x163 stage: load/enable/data controls in, Q bits and ripple carry out.
// The clock and the clear stay as plain ports on the counter itself.
interface mod_74x163_if;
    logic LOAD_n;
    logic ENP;
    logic ENT;
    logic A;
    logic B;
    logic C;
    logic D;
    logic QA;
    logic QB;
    logic QC;
    logic QD;
    logic RCO;

    modport master (
        output LOAD_n, ENP, ENT, A, B, C, D,
        input  QA, QB, QC, QD, RCO
    );

    modport slave (
        input  LOAD_n, ENP, ENT, A, B, C, D,
        output QA, QB, QC, QD, RCO
    );
endinterface

// File: rtl/mod_74x163.sv
// Synchronous 4-bit binary counter modelled on the 74x163.
// Priority on each edge: clear, then parallel load, then count, otherwise hold.
module mod_74x163 (
    input  logic          CLK,
    input  logic          CLR_n,
    mod_74x163_if.slave   bus
);

    typedef enum logic [1:0] {
        OP_HOLD,
        OP_COUNT,
        OP_LOAD
    } op_e;

    op_e        op;
    logic [3:0] load_val;
    logic [3:0] q_d;
    logic [3:0] q_q;

    // Load ignores both enables; counting needs ENP and ENT together.
    always_comb begin
        load_val = {bus.D, bus.C, bus.B, bus.A};
        op       = OP_HOLD;
        if (!bus.LOAD_n) begin
            op = OP_LOAD;
        end else if (bus.ENP && bus.ENT) begin
            op = OP_COUNT;
        end
    end

    always_comb begin
        q_d = q_q;
        case (op)
            OP_LOAD:  q_d = load_val;
            OP_COUNT: q_d = q_q + 4'd1;
            default:  q_d = q_q;
        endcase
    end

    // CLR_n is the synchronous clear and overrides every other control.
    always_ff @(posedge CLK) begin
        if (!CLR_n) begin
            q_q <= 4'd0;
        end else begin
            q_q <= q_d;
        end
    end

    assign bus.QA  = q_q[0];
    assign bus.QB  = q_q[1];
    assign bus.QC  = q_q[2];
    assign bus.QD  = q_q[3];

    // Ripple carry is purely combinational so the next stage sees it within the same cycle.
    assign bus.RCO = bus.ENT & (&q_q);

endmodule

// File: tb/tb_mod_74x163.sv
// Self-checking bench for mod_74x163: directed scenarios, a two-stage cascade and a random run
// against a behavioural counter model.
module tb_mod_74x163;

    logic       CLK = 1'b0;
    logic       clr_n;
    logic       load_n;
    logic       enp;
    logic       ent;
    logic [3:0] data;

    int model_q;
    int n_vec;
    int n_err;

    mod_74x163_if bus0 ();
    mod_74x163_if bus1 ();

    assign bus0.LOAD_n = load_n;
    assign bus0.ENP    = enp;
    assign bus0.ENT    = ent;
    assign {bus0.D, bus0.C, bus0.B, bus0.A} = data;

    // Second stage chained off the first: its trickle enable is stage 0's ripple carry.
    assign bus1.LOAD_n = 1'b1;
    assign bus1.ENP    = enp;
    assign bus1.ENT    = bus0.RCO;
    assign {bus1.D, bus1.C, bus1.B, bus1.A} = 4'd0;

    mod_74x163 dut0 (.CLK(CLK), .CLR_n(clr_n), .bus(bus0));
    mod_74x163 dut1 (.CLK(CLK), .CLR_n(clr_n), .bus(bus1));

    logic [3:0] q0;
    logic [3:0] q1;
    assign q0 = {bus0.QD, bus0.QC, bus0.QB, bus0.QA};
    assign q1 = {bus1.QD, bus1.QC, bus1.QB, bus1.QA};

    always #5 CLK = ~CLK;

    // Advance one rising edge, updating the reference count from the controls held across it.
    task automatic step();
        int nxt;
        if (!clr_n)               nxt = 0;
        else if (!load_n)         nxt = int'(data);
        else if (enp && ent)      nxt = (model_q + 1) % 16;
        else                      nxt = model_q;
        @(posedge CLK);
        #1;
        model_q = nxt;
    endtask

    task automatic test_reset();
        clr_n = 1'b0; load_n = 1'b1; enp = 1'b1; ent = 1'b1; data = 4'b1010;
        step();
        step();
        n_vec++;
        if (q0 !== 4'd0) begin n_err++; $display("[TB] FAIL reset_q: got %0d expected 0", q0); end
        n_vec++;
        if (bus0.RCO !== 1'b0) begin n_err++; $display("[TB] FAIL reset_rco: got %b expected 0", bus0.RCO); end
        n_vec++;
        if (q1 !== 4'd0) begin n_err++; $display("[TB] FAIL reset_q1: got %0d expected 0", q1); end
        clr_n = 1'b1;
        step();
        n_vec++;
        if (q0 !== 4'd1) begin n_err++; $display("[TB] FAIL reset_release: got %0d expected 1", q0); end
    endtask

    task automatic test_count_wrap();
        clr_n = 1'b0;
        step();
        clr_n = 1'b1; load_n = 1'b1; enp = 1'b1; ent = 1'b1;
        for (int i = 0; i < 16; i++) begin
            n_vec++;
            if (bus0.RCO !== (i == 15)) begin
                n_err++; $display("[TB] FAIL wrap_rco at q=%0d: got %b expected %b", i, bus0.RCO, (i == 15));
            end
            step();
            n_vec++;
            if (q0 !== 4'((i + 1) % 16)) begin
                n_err++; $display("[TB] FAIL wrap_q step %0d: got %0d expected %0d", i, q0, (i + 1) % 16);
            end
        end
        n_vec++;
        if (bus0.RCO !== 1'b0) begin n_err++; $display("[TB] FAIL wrap_rco_fall: got %b expected 0", bus0.RCO); end
    endtask

    task automatic test_load_priority();
        data = 4'd9; load_n = 1'b0; enp = 1'b0; ent = 1'b0;
        step();
        n_vec++;
        if (q0 !== 4'd9) begin n_err++; $display("[TB] FAIL load_q: got %0d expected 9", q0); end
        clr_n = 1'b0; load_n = 1'b0;
        step();
        n_vec++;
        if (q0 !== 4'd0) begin n_err++; $display("[TB] FAIL clear_over_load: got %0d expected 0", q0); end
        clr_n = 1'b1; load_n = 1'b1;
    endtask

    task automatic test_enables();
        data = 4'd15; load_n = 1'b0; enp = 1'b0; ent = 1'b1;
        step();
        n_vec++;
        if (bus0.RCO !== 1'b1) begin n_err++; $display("[TB] FAIL load15_rco: got %b expected 1", bus0.RCO); end
        load_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            n_vec++;
            if (q0 !== 4'd15) begin n_err++; $display("[TB] FAIL enp_hold_q cycle %0d: got %0d expected 15", i, q0); end
            n_vec++;
            if (bus0.RCO !== 1'b1) begin n_err++; $display("[TB] FAIL enp_hold_rco cycle %0d: got %b expected 1", i, bus0.RCO); end
        end
        ent = 1'b0;
        #1;
        n_vec++;
        if (bus0.RCO !== 1'b0) begin n_err++; $display("[TB] FAIL ent_gates_rco: got %b expected 0", bus0.RCO); end
        n_vec++;
        if (q0 !== 4'd15) begin n_err++; $display("[TB] FAIL ent_low_q: got %0d expected 15", q0); end
    endtask

    task automatic test_cascade();
        int cnt;
        clr_n = 1'b0;
        step();
        clr_n = 1'b1; load_n = 1'b1; enp = 1'b1; ent = 1'b1;
        cnt = 0;
        for (int i = 0; i < 256; i++) begin
            n_vec++;
            if ({q1, q0} !== 8'(cnt) || bus1.RCO !== (cnt == 255)) begin
                n_err++;
                $display("[TB] FAIL cascade edge %0d: got count %0d rco1 %b expected count %0d rco1 %b",
                         i, {q1, q0}, bus1.RCO, cnt, (cnt == 255));
            end
            step();
            cnt = (cnt + 1) % 256;
        end
        n_vec++;
        if ({q1, q0} !== 8'd0 || bus1.RCO !== 1'b0) begin
            n_err++; $display("[TB] FAIL cascade_wrap: got count %0d rco1 %b expected 0 0", {q1, q0}, bus1.RCO);
        end
    endtask

    task automatic test_mid_clear();
        clr_n = 1'b0;
        step();
        clr_n = 1'b1; load_n = 1'b1; enp = 1'b1; ent = 1'b1;
        repeat (7) step();
        n_vec++;
        if (q0 !== 4'd7) begin n_err++; $display("[TB] FAIL mid_count7: got %0d expected 7", q0); end
        clr_n = 1'b0; load_n = 1'b0; data = 4'd12;
        step();
        n_vec++;
        if (q0 !== 4'd0) begin n_err++; $display("[TB] FAIL mid_clear: got %0d expected 0", q0); end
        clr_n = 1'b1; load_n = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            step();
            n_vec++;
            if (q0 !== 4'(i)) begin n_err++; $display("[TB] FAIL mid_resume: got %0d expected %0d", q0, i); end
        end
    endtask

    task automatic test_random();
        clr_n = 1'b0;
        step();
        for (int i = 0; i < 300; i++) begin
            clr_n  = ($urandom_range(0, 15) != 0);
            load_n = ($urandom_range(0, 3) != 0);
            enp    = 1'($urandom_range(0, 1));
            ent    = 1'($urandom_range(0, 1));
            data   = 4'($urandom);
            #1;
            n_vec++;
            if (bus0.RCO !== (ent && model_q == 15)) begin
                n_err++; $display("[TB] FAIL rand_rco_comb iter %0d: got %b expected %b", i, bus0.RCO, (ent && model_q == 15));
            end
            step();
            n_vec++;
            if (q0 !== 4'(model_q) || bus0.RCO !== (ent && model_q == 15)) begin
                n_err++;
                $display("[TB] FAIL rand_q iter %0d: got q %0d rco %b expected q %0d rco %b",
                         i, q0, bus0.RCO, model_q, (ent && model_q == 15));
            end
        end
    endtask

    initial begin
        n_vec = 0; n_err = 0; model_q = 0;
        clr_n = 1'b1; load_n = 1'b1; enp = 1'b0; ent = 1'b0; data = 4'd0;
        @(negedge CLK);
        test_reset();
        test_count_wrap();
        test_load_priority();
        test_enables();
        test_cascade();
        test_mid_clear();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
